findmax_frame_ctrl: RTL and testbench
=====================================

// Module: findmax_frame_ctrl
// PURPOSE
//  Sequences the findmax HLS core over one GCC-PHAT correlation frame per start request.
//  Gates the upstream correlation AXIS stream into the core and inserts TLAST at the frame boundary.
//  Captures the core's argmax result and reports it to the delay-estimation logic.
//  Optional watchdog recovers the core when its deadlock monitor reports a persistent block.
// PARAMETERS
//  DATA_W      32     correlation sample width (signed)
//  IDX_W       10     index width; frame length 1..2**IDX_W
//  TIMEOUT_CYC 1024   consecutive blocked cycles before abort (watchdog build only)
// PORTS
//  clock          in   1        single clock domain
//  reset          in   1        synchronous, active-high
//  start          in   1        begin frame; sampled in IDLE only
//  cfg_len        in   IDX_W+1  frame length in samples, latched on accepted start
//  s_tdata        in   DATA_W   upstream correlation sample
//  s_tvalid       in   1        upstream valid
//  s_tready       out  1        upstream ready
//  m_tdata        out  DATA_W   to findmax core
//  m_tvalid       out  1        to findmax core
//  m_tlast        out  1        last beat of frame
//  m_tready       in   1        from findmax core
//  res_idx        in   IDX_W    core result index
//  res_val        in   DATA_W   core result peak value
//  res_valid      in   1        core result valid
//  res_ready      out  1        result accept
//  blk            in   1        block output of findmax deadlock monitor
//  busy           out  1        state != IDLE
//  done           out  1        1-cycle pulse, result registers updated
//  peak_idx       out  IDX_W    registered argmax
//  peak_val       out  DATA_W   registered peak value
//  cfg_err        out  1        1-cycle pulse: start with cfg_len==0 or cfg_len > 2**IDX_W
//  err_timeout    out  1        sticky watchdog abort flag
//  core_rst       out  1        1-cycle reset pulse to findmax core on abort
// BEHAVIOUR
//  Reset values:
//   - FSM=IDLE; all outputs 0, including peak_idx/peak_val, s_tready, m_tvalid, res_ready.
//  FSM states: IDLE, STREAM, WAIT_RES, ABORT.
//  IDLE:
//   - start with cfg_len valid: latch len, clear beat cnt, clear err_timeout -> STREAM.
//   - start with cfg_len invalid: cfg_err pulse, stay IDLE.
//  STREAM:
//   - Combinational pass-through: m_tdata=s_tdata, m_tvalid=s_tvalid, s_tready=m_tready.
//   - Beat is a transfer on s_tvalid&m_tready; cnt increments per beat.
//   - m_tlast = (cnt==len-1); the beat that transfers with m_tlast -> WAIT_RES.
//   - len=1: first beat carries TLAST.
//  WAIT_RES:
//   - res_ready=1, s_tready=0, m_tvalid=0.
//   - res_valid: register res_idx/res_val, done=1 next cycle, -> IDLE.
//  Outside STREAM: s_tready=0, m_tvalid=0; upstream backpressured, no data dropped.
//  Start while busy: ignored, no error.
//  Latency: done asserts 1 cycle after the res_valid&res_ready handshake.
//  A result arriving during STREAM is not accepted (res_ready=0); core holds it.
//  Reset mid-frame returns to IDLE immediately; the partial frame is discarded and the core is not
//  reset by this block.
// CONFIGURATION
//  FINDMAX_CTRL_WATCHDOG_EN defined:
//   - In STREAM/WAIT_RES, wd counter increments while blk=1 and clears when blk=0.
//   - wd==TIMEOUT_CYC-1 with blk=1 -> ABORT.
//   - ABORT (1 cycle): core_rst=1, err_timeout<=1, no done -> IDLE.
//   - err_timeout stays high until the next accepted start or reset.
//  FINDMAX_CTRL_WATCHDOG_EN undefined:
//   - No counter; blk ignored; ABORT unreachable; err_timeout and core_rst tied 0.
// STRUCTURE
//  Package findmax_ctrl_pkg:
//   - FSM state enum, IDX_W and DATA_W defaults, function len_ok(cfg_len).
//  Sub-module findmax_ctrl_wdog:
//   - Saturating blocked-cycle counter with clear, expired output.
//   - Instantiated only under the macro.
//  Rest is a single FSM plus beat counter.
// TESTING
//  - len=4, s_tvalid/m_tready always 1: 4 beats, m_tlast on beat 3; res_idx=2,res_val=0x7F
//    -> done pulse, peak_idx=2, peak_val=0x7F.
//  - len=8, m_tready toggling 1010..: exactly 8 transfers, s_tready follows m_tready, no data lost.
//  - cfg_len=0 start -> cfg_err pulse, busy stays 0.
//  - start asserted during STREAM -> ignored, frame completes normally.
//  - len=1 -> single beat with m_tlast=1 -> WAIT_RES.
//  - Watchdog build, TIMEOUT_CYC=16, blk held 1 in WAIT_RES -> core_rst pulse 16 cycles later,
//    err_timeout=1, busy=0, done=0.
//    blk pulsed 15 cycles then 0 -> no abort.

Source files
------------

// File: rtl/findmax_ctrl_pkg.sv
// ============================================================================
// Module   : findmax_ctrl_pkg
// Contents : FSM state encoding, default widths and frame-length check for
//            the findmax frame controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package findmax_ctrl_pkg;

   localparam int c_DEF_DATA_W = 32;
   localparam int c_DEF_IDX_W  = 10;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_STREAM   = 2'd1,
      ST_WAIT_RES = 2'd2,
      ST_ABORT    = 2'd3
   } state_t;

   // Legal frame lengths are 1 .. 2**idx_w (idx_w up to 31).
   function automatic logic len_ok(input logic [31:0] len, input int idx_w);
      logic [32:0] max_len;
      max_len = 33'd1 << idx_w;
      return (len != 32'd0) && ({1'b0, len} <= max_len);
   endfunction

endpackage

`default_nettype wire

// File: rtl/findmax_ctrl_wdog.sv
// ============================================================================
// Module   : findmax_ctrl_wdog
// Contents : Saturating blocked-cycle counter; flags expiry on the last
//            consecutive blocked cycle before the timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module findmax_ctrl_wdog #(
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic clock,
   input  logic reset,
   input  logic enable,
   input  logic blk,
   output logic expired
);

   localparam int                 c_CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [c_CNT_W-1:0] c_MAX   = c_CNT_W'(TIMEOUT_CYC - 1);

   logic [c_CNT_W-1:0] r_cnt;

   always_ff @(posedge clock) begin
      if (reset || !enable || !blk) begin
         r_cnt <= '0;
      end else if (r_cnt != c_MAX) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign expired = enable && blk && (r_cnt == c_MAX);

endmodule

`default_nettype wire

// File: rtl/findmax_frame_ctrl.sv
// ============================================================================
// Module   : findmax_frame_ctrl
// Contents : Frames one correlation block into the findmax core and captures
//            its argmax result. Watchdog abort enabled by
//            FINDMAX_CTRL_WATCHDOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module findmax_frame_ctrl
   import findmax_ctrl_pkg::*;
#(
   parameter int DATA_W      = c_DEF_DATA_W,
   parameter int IDX_W       = c_DEF_IDX_W,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [IDX_W:0]    cfg_len,
   input  logic [DATA_W-1:0] s_tdata,
   input  logic              s_tvalid,
   output logic              s_tready,
   output logic [DATA_W-1:0] m_tdata,
   output logic              m_tvalid,
   output logic              m_tlast,
   input  logic              m_tready,
   input  logic [IDX_W-1:0]  res_idx,
   input  logic [DATA_W-1:0] res_val,
   input  logic              res_valid,
   output logic              res_ready,
   input  logic              blk,
   output logic              busy,
   output logic              done,
   output logic [IDX_W-1:0]  peak_idx,
   output logic [DATA_W-1:0] peak_val,
   output logic              cfg_err,
   output logic              err_timeout,
   output logic              core_rst
);

`ifdef FINDMAX_CTRL_WATCHDOG_EN
   localparam bit c_WD_EN = 1'b1;
`else
   localparam bit c_WD_EN = 1'b0;
`endif

   state_t              r_state;
   state_t              w_state_nxt;
   logic [IDX_W:0]      r_len;
   logic [IDX_W-1:0]    r_cnt;
   logic                r_done;
   logic                r_cfg_err;
   logic                r_err_timeout;
   logic [IDX_W-1:0]    r_peak_idx;
   logic [DATA_W-1:0]   r_peak_val;

   logic                w_len_ok;
   logic                w_start_ok;
   logic                w_start_bad;
   logic                w_beat;
   logic                w_last;
   logic                w_res_hs;
   logic                w_wd_expired;

   assign w_len_ok    = len_ok(32'(cfg_len), IDX_W);
   assign w_start_ok  = (r_state == ST_IDLE) && start && w_len_ok;
   assign w_start_bad = (r_state == ST_IDLE) && start && !w_len_ok;
   assign w_beat      = (r_state == ST_STREAM) && s_tvalid && m_tready;
   assign w_last      = ({1'b0, r_cnt} == (r_len - 1'b1));
   assign w_res_hs    = (r_state == ST_WAIT_RES) && res_valid;

`ifdef FINDMAX_CTRL_WATCHDOG_EN
   logic w_wd_en;
   assign w_wd_en = (r_state == ST_STREAM) || (r_state == ST_WAIT_RES);

   findmax_ctrl_wdog #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_wdog (
      .clock   (clock),
      .reset   (reset),
      .enable  (w_wd_en),
      .blk     (blk),
      .expired (w_wd_expired)
   );
`else
   logic w_unused;
   assign w_unused     = &{1'b0, blk, (TIMEOUT_CYC > 0)};
   assign w_wd_expired = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      s_tready    = 1'b0;
      m_tvalid    = 1'b0;
      m_tdata     = '0;
      m_tlast     = 1'b0;
      res_ready   = 1'b0;
      core_rst    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_start_ok) begin
               w_state_nxt = ST_STREAM;
            end
         end
         ST_STREAM: begin
            s_tready = m_tready;
            m_tvalid = s_tvalid;
            m_tdata  = s_tdata;
            m_tlast  = w_last;
            if (w_wd_expired) begin
               w_state_nxt = ST_ABORT;
            end else if (w_beat && w_last) begin
               w_state_nxt = ST_WAIT_RES;
            end
         end
         ST_WAIT_RES: begin
            res_ready = 1'b1;
            // An arriving result wins over a same-cycle watchdog expiry.
            if (res_valid) begin
               w_state_nxt = ST_IDLE;
            end else if (w_wd_expired) begin
               w_state_nxt = ST_ABORT;
            end
         end
         ST_ABORT: begin
            core_rst    = c_WD_EN;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_len         <= '0;
         r_cnt         <= '0;
         r_done        <= 1'b0;
         r_cfg_err     <= 1'b0;
         r_err_timeout <= 1'b0;
         r_peak_idx    <= '0;
         r_peak_val    <= '0;
      end else begin
         r_done    <= w_res_hs;
         r_cfg_err <= w_start_bad;
         if (w_start_ok) begin
            r_len         <= cfg_len;
            r_cnt         <= '0;
            r_err_timeout <= 1'b0;
         end else if (w_beat) begin
            r_cnt <= r_cnt + 1'b1;
         end
         if (c_WD_EN && (r_state == ST_ABORT)) begin
            r_err_timeout <= 1'b1;
         end
         if (w_res_hs) begin
            r_peak_idx <= res_idx;
            r_peak_val <= res_val;
         end
      end
   end

   assign busy        = (r_state != ST_IDLE);
   assign done        = r_done;
   assign peak_idx    = r_peak_idx;
   assign peak_val    = r_peak_val;
   assign cfg_err     = r_cfg_err;
   assign err_timeout = c_WD_EN ? r_err_timeout : 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_findmax_frame_ctrl.sv
// ============================================================================
// Module   : tb_findmax_frame_ctrl
// Contents : Directed self-checking bench for findmax_frame_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_findmax_frame_ctrl;

   localparam int DATA_W = 32;
   localparam int IDX_W  = 10;

   logic              clock = 1'b0;
   logic              reset;
   logic              start;
   logic [IDX_W:0]    cfg_len;
   logic [DATA_W-1:0] s_tdata;
   logic              s_tvalid;
   logic              s_tready;
   logic [DATA_W-1:0] m_tdata;
   logic              m_tvalid;
   logic              m_tlast;
   logic              m_tready;
   logic [IDX_W-1:0]  res_idx;
   logic [DATA_W-1:0] res_val;
   logic              res_valid;
   logic              res_ready;
   logic              blk;
   logic              busy;
   logic              done;
   logic [IDX_W-1:0]  peak_idx;
   logic [DATA_W-1:0] peak_val;
   logic              cfg_err;
   logic              err_timeout;
   logic              core_rst;

   int n_checks = 0;
   int n_errors = 0;

   findmax_frame_ctrl #(
      .DATA_W      (DATA_W),
      .IDX_W       (IDX_W),
      .TIMEOUT_CYC (16)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .cfg_len     (cfg_len),
      .s_tdata     (s_tdata),
      .s_tvalid    (s_tvalid),
      .s_tready    (s_tready),
      .m_tdata     (m_tdata),
      .m_tvalid    (m_tvalid),
      .m_tlast     (m_tlast),
      .m_tready    (m_tready),
      .res_idx     (res_idx),
      .res_val     (res_val),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .blk         (blk),
      .busy        (busy),
      .done        (done),
      .peak_idx    (peak_idx),
      .peak_val    (peak_val),
      .cfg_err     (cfg_err),
      .err_timeout (err_timeout),
      .core_rst    (core_rst)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   // Start a one-beat frame and leave the DUT sitting in WAIT_RES.
   task automatic enter_wait1;
      start   = 1'b1;
      cfg_len = 11'd1;
      tick();
      start    = 1'b0;
      s_tvalid = 1'b1;
      m_tready = 1'b1;
      tick();
      s_tvalid = 1'b0;
   endtask

   initial begin
      int beats;
      int xfers;
      int guard;

      reset = 1'b1; start = 1'b0; cfg_len = '0; s_tdata = '0; s_tvalid = 1'b0;
      m_tready = 1'b0; res_idx = '0; res_val = '0; res_valid = 1'b0; blk = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      s_tvalid = 1'b1; m_tready = 1'b1; s_tdata = 32'h1234;
      #1;
      chk("rst_busy",        busy,        1'b0);
      chk("rst_done",        done,        1'b0);
      chk("rst_peak_idx",    peak_idx,    '0);
      chk("rst_peak_val",    peak_val,    '0);
      chk("rst_s_tready",    s_tready,    1'b0);
      chk("rst_m_tvalid",    m_tvalid,    1'b0);
      chk("rst_res_ready",   res_ready,   1'b0);
      chk("rst_cfg_err",     cfg_err,     1'b0);
      chk("rst_err_timeout", err_timeout, 1'b0);
      chk("rst_core_rst",    core_rst,    1'b0);

      // len=4, continuous flow
      start = 1'b1; cfg_len = 11'd4;
      tick();
      start = 1'b0;
      chk("l4_busy", busy, 1'b1);
      for (int k = 0; k < 4; k++) begin
         s_tdata = 32'(100 + k);
         #1;
         chk("l4_m_tdata",   m_tdata,  32'(100 + k));
         chk("l4_m_tvalid",  m_tvalid, 1'b1);
         chk("l4_s_tready",  s_tready, 1'b1);
         chk("l4_m_tlast",   m_tlast,  (k == 3) ? 1'b1 : 1'b0);
         tick();
      end
      #1;
      chk("l4_wait_res_ready", res_ready, 1'b1);
      chk("l4_wait_s_tready",  s_tready,  1'b0);
      chk("l4_wait_m_tvalid",  m_tvalid,  1'b0);
      chk("l4_wait_done",      done,      1'b0);
      res_valid = 1'b1; res_idx = 10'd2; res_val = 32'h7F;
      tick();
      res_valid = 1'b0;
      chk("l4_done",     done,     1'b1);
      chk("l4_peak_idx", peak_idx, 10'd2);
      chk("l4_peak_val", peak_val, 32'h7F);
      chk("l4_busy_end", busy,     1'b0);
      tick();
      chk("l4_done_pulse", done, 1'b0);

      // len=8, m_tready toggling, start and early result held during the frame
      start = 1'b1; cfg_len = 11'd8;
      tick();
      cfg_len = 11'd3;
      res_valid = 1'b1; res_idx = 10'd5; res_val = 32'hFFFF_FFFD;
      beats = 0; xfers = 0; guard = 0;
      while (beats < 8 && guard < 40) begin
         m_tready = (guard % 2 == 0);
         s_tvalid = 1'b1;
         s_tdata  = 32'(200 + beats);
         #1;
         chk("l8_s_tready",  s_tready,  m_tready);
         chk("l8_m_tdata",   m_tdata,   32'(200 + beats));
         chk("l8_m_tlast",   m_tlast,   (beats == 7) ? 1'b1 : 1'b0);
         chk("l8_res_ready", res_ready, 1'b0);
         chk("l8_cfg_err",   cfg_err,   1'b0);
         if (m_tvalid && m_tready) xfers++;
         if (m_tready) beats++;
         guard++;
         tick();
      end
      start = 1'b0; s_tvalid = 1'b1; m_tready = 1'b1;
      #1;
      chk("l8_xfers",     xfers,     8);
      chk("l8_cycles",    guard,     15);
      chk("l8_res_ready", res_ready, 1'b1);
      chk("l8_s_tready",  s_tready,  1'b0);
      tick();
      res_valid = 1'b0;
      chk("l8_done",     done,     1'b1);
      chk("l8_peak_idx", peak_idx, 10'd5);
      chk("l8_peak_val", peak_val, 32'hFFFF_FFFD);
      chk("l8_busy",     busy,     1'b0);

      // illegal lengths
      start = 1'b1; cfg_len = 11'd0;
      tick();
      start = 1'b0;
      chk("len0_cfg_err", cfg_err, 1'b1);
      chk("len0_busy",    busy,    1'b0);
      tick();
      chk("len0_cfg_err_pulse", cfg_err, 1'b0);
      start = 1'b1; cfg_len = 11'd1025;
      tick();
      start = 1'b0;
      chk("len1025_cfg_err", cfg_err, 1'b1);
      chk("len1025_busy",    busy,    1'b0);

      // len=1, with an idle upstream cycle first
      start = 1'b1; cfg_len = 11'd1;
      tick();
      start = 1'b0; s_tvalid = 1'b0; m_tready = 1'b1;
      #1;
      chk("l1_idle_m_tvalid", m_tvalid, 1'b0);
      chk("l1_idle_s_tready", s_tready, 1'b1);
      tick();
      s_tvalid = 1'b1; s_tdata = 32'hABCD;
      #1;
      chk("l1_m_tlast",  m_tlast,  1'b1);
      chk("l1_m_tvalid", m_tvalid, 1'b1);
      tick();
      chk("l1_res_ready", res_ready, 1'b1);
      chk("l1_s_tready",  s_tready,  1'b0);

      // WAIT_RES with blk held high
`ifdef FINDMAX_CTRL_WATCHDOG_EN
      blk = 1'b1;
      for (int k = 0; k < 16; k++) begin
         #1;
         chk("wd_no_core_rst_yet", core_rst, 1'b0);
         tick();
      end
      chk("wd_core_rst", core_rst, 1'b1);
      chk("wd_abort_done", done, 1'b0);
      tick();
      blk = 1'b0;
      chk("wd_err_timeout", err_timeout, 1'b1);
      chk("wd_busy",        busy,        1'b0);
      chk("wd_done",        done,        1'b0);
      chk("wd_core_rst_pulse", core_rst, 1'b0);
      enter_wait1();
      chk("wd_err_cleared", err_timeout, 1'b0);
      blk = 1'b1;
      repeat (15) tick();
      blk = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("wd15_no_core_rst", core_rst, 1'b0);
         tick();
      end
      chk("wd15_busy", busy, 1'b1);
`else
      blk = 1'b1;
      for (int k = 0; k < 20; k++) begin
         #1;
         chk("nowd_core_rst", core_rst, 1'b0);
         tick();
      end
      blk = 1'b0;
      chk("nowd_busy",        busy,        1'b1);
      chk("nowd_err_timeout", err_timeout, 1'b0);
`endif
      res_valid = 1'b1; res_idx = 10'd0; res_val = 32'h8000_0000;
      tick();
      res_valid = 1'b0;
      chk("l1_done",     done,     1'b1);
      chk("l1_peak_idx", peak_idx, 10'd0);
      chk("l1_peak_val", peak_val, 32'h8000_0000);

      // len=1024, maximum frame
      start = 1'b1; cfg_len = 11'd1024;
      tick();
      start = 1'b0; s_tvalid = 1'b1; m_tready = 1'b1;
      for (int k = 0; k < 1024; k++) begin
         s_tdata = 32'(k);
         #1;
         if (k == 0 || k == 1022) chk("l1024_no_tlast", m_tlast, 1'b0);
         if (k == 1023) chk("l1024_tlast", m_tlast, 1'b1);
         tick();
      end
      chk("l1024_res_ready", res_ready, 1'b1);
      res_valid = 1'b1; res_idx = 10'h3FF; res_val = 32'h0000_1000;
      tick();
      res_valid = 1'b0;
      chk("l1024_done",     done,     1'b1);
      chk("l1024_peak_idx", peak_idx, 10'h3FF);

      // reset in the middle of a frame
      start = 1'b1; cfg_len = 11'd4;
      tick();
      start = 1'b0;
      repeat (2) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      chk("mrst_busy",     busy,     1'b0);
      chk("mrst_s_tready", s_tready, 1'b0);
      chk("mrst_m_tvalid", m_tvalid, 1'b0);
      chk("mrst_peak_idx", peak_idx, '0);
      chk("mrst_core_rst", core_rst, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
